// File: rtl/irq_latch_arbiter.sv
// ============================================================================
// Module      : irq_latch_arbiter
// Description : Latches rising edges on 8 interrupt lines, masks them with an
//               enable register and presents the highest eligible index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_latch_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       en_we,
    input  logic [7:0] en_in,
    input  logic       irq_ack,
    output logic [7:0] pending,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] overrun
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q, req_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] overrun_q, overrun_d;
    logic [7:0] en_q, en_d;
    logic [2:0] id_q, id_d;

    logic [7:0] w_rise;
    logic [7:0] w_eligible;
    logic [7:0] w_clr;
    logic [2:0] w_top;

    always_comb begin
        w_rise     = req & ~req_q;
        w_eligible = pending_q & en_q;

        // Ascending scan: the last hit is the highest set index.
        w_top = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_eligible[i]) begin
                w_top = 3'(i);
            end
        end

        state_d = state_q;
        id_d    = id_q;
        w_clr   = 8'h00;

        case (state_q)
            IDLE: begin
                if (w_eligible != 8'h00) begin
                    state_d = PRESENT;
                    id_d    = w_top;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    w_clr        = 8'h00;
                    w_clr[id_q]  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge coinciding with the ack of its own line re-arms the bit
        // without counting as an overrun.
        req_d     = req;
        pending_d = (pending_q & ~w_clr) | w_rise;
        overrun_d = overrun_q | (w_rise & pending_q & ~w_clr);
        en_d      = en_we ? en_in : en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 8'hFF;
            pending_q <= 8'h00;
            overrun_q <= 8'h00;
            en_q      <= 8'h00;
            id_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            en_q      <= en_d;
            id_q      <= id_d;
        end
    end

    assign pending   = pending_q;
    assign overrun   = overrun_q;
    assign irq_valid = (state_q == PRESENT);
    assign irq_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_latch_arbiter.sv
// ============================================================================
// Module      : tb_irq_latch_arbiter
// Description : Directed bench; expected ids are queued by the stimulus and
//               checked by a monitor on each new presentation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_latch_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       en_we;
    logic [7:0] en_in;
    logic       irq_ack;
    logic [7:0] pending;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] overrun;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic       prev_valid = 1'b0;

    irq_latch_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en_we     (en_we),
        .en_in     (en_in),
        .irq_ack   (irq_ack),
        .pending   (pending),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: every fresh presentation must match the next queued id.
    always @(negedge clk) begin
        if (irq_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL irq_id_unexpected: got id %0d, no presentation expected", irq_id);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (irq_id !== e) begin
                    errors++;
                    $display("FAIL irq_id_order: got %0d, expected %0d", irq_id, e);
                end
            end
        end
        prev_valid = irq_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
        end
    endtask

    task automatic write_en(input logic [7:0] v);
        en_we = 1'b1;
        en_in = v;
        step();
        en_we = 1'b0;
    endtask

    // Bounded wait for a presentation, then acknowledge it for one cycle.
    task automatic wait_and_ack(input string name);
        int n;
        n = 0;
        while (!irq_valid && n < 8) begin
            step();
            n++;
        end
        chk({name, "_valid"}, {7'd0, irq_valid}, 8'h01);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk({name, "_drop"}, {7'd0, irq_valid}, 8'h00);
    endtask

    initial begin
        rst     = 1'b1;
        req     = 8'h00;
        en_we   = 1'b0;
        en_in   = 8'h00;
        irq_ack = 1'b0;
        step();
        step();
        chk("rst_pending", pending, 8'h00);
        chk("rst_overrun", overrun, 8'h00);
        chk("rst_valid", {7'd0, irq_valid}, 8'h00);
        chk("rst_id", {5'd0, irq_id}, 8'h00);
        rst = 1'b0;
        step();

        // Single request
        write_en(8'hFF);
        req = 8'h08;
        exp_q.push_back(3'd3);
        step();
        chk("single_pending_same_edge", pending, 8'h08);
        chk("single_valid_not_yet", {7'd0, irq_valid}, 8'h00);
        step();
        chk("single_valid_next_edge", {7'd0, irq_valid}, 8'h01);
        wait_and_ack("single");
        chk("single_pending_cleared", pending, 8'h00);
        req = 8'h00;
        step();

        // Priority 6, 5, 1
        req = 8'h62;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd1);
        step();
        chk("prio_pending", pending, 8'h62);
        wait_and_ack("prio6");
        chk("prio_pending_after6", pending, 8'h22);
        wait_and_ack("prio5");
        chk("prio_pending_after5", pending, 8'h02);
        wait_and_ack("prio1");
        chk("prio_pending_after1", pending, 8'h00);
        req = 8'h00;
        step();

        // Masking, and en write using the old value at the same edge
        write_en(8'h01);
        req = 8'h10;
        step();
        chk("mask_pending", pending, 8'h10);
        step();
        step();
        chk("mask_no_valid", {7'd0, irq_valid}, 8'h00);
        exp_q.push_back(3'd4);
        write_en(8'h10);
        chk("mask_write_edge_old_en", {7'd0, irq_valid}, 8'h00);
        step();
        chk("mask_valid_after_write", {7'd0, irq_valid}, 8'h01);
        wait_and_ack("mask");
        req = 8'h00;
        step();

        // Overrun, then ack coinciding with a new edge on the same line
        write_en(8'hFF);
        exp_q.push_back(3'd2);
        req = 8'h04;
        step();
        req = 8'h00;
        step();
        chk("ovr_presenting", {7'd0, irq_valid}, 8'h01);
        req = 8'h04;
        step();
        chk("ovr_set", overrun, 8'h04);
        req = 8'h00;
        step();
        exp_q.push_back(3'd2);
        req = 8'h04;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        req = 8'h00;
        chk("ack_edge_pending_kept", pending, 8'h04);
        chk("ack_edge_overrun_same", overrun, 8'h04);
        chk("ack_edge_valid_drop", {7'd0, irq_valid}, 8'h00);
        wait_and_ack("represent");
        chk("represent_pending", pending, 8'h00);

        // Stray ack in IDLE with a masked pending bit
        write_en(8'h00);
        req = 8'h01;
        step();
        req = 8'h00;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("stray_pending", pending, 8'h01);
        chk("stray_valid", {7'd0, irq_valid}, 8'h00);
        chk("stray_overrun", overrun, 8'h04);
        chk("stray_id", {5'd0, irq_id}, 8'h02);

        // Reset during a presentation
        exp_q.push_back(3'd0);
        write_en(8'hFF);
        step();
        chk("rstp_valid_before", {7'd0, irq_valid}, 8'h01);
        rst = 1'b1;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("rstp_valid", {7'd0, irq_valid}, 8'h00);
        chk("rstp_pending", pending, 8'h00);
        chk("rstp_overrun", overrun, 8'h00);
        chk("rstp_id", {5'd0, irq_id}, 8'h00);
        rst = 1'b0;
        step();
        req = 8'h02;
        step();
        step();
        step();
        chk("rstp_en_cleared_pending", pending, 8'h02);
        chk("rstp_en_cleared_valid", {7'd0, irq_valid}, 8'h00);

        // Lines held high through reset release are not edges
        rst = 1'b1;
        req = 8'hFF;
        step();
        rst = 1'b0;
        step();
        step();
        chk("held_high_pending", pending, 8'h00);
        req = 8'h00;
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL presentations_missing: got %0d left in queue, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
